mmio_uart_ctrl: RTL and testbench

MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

---
 rtl/mmio_uart_ctrl_pkg.sv | 32 +++
 rtl/mmio_uart_ctrl_sync_fifo.sv | 68 ++++++
 rtl/mmio_uart_ctrl.sv | 121 ++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared constants for the MMIO UART controller: bus width, IO region
// nibble, register word offsets and the status/level packing helpers.
package mmio_uart_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  // Byte address bits [31:28] that select the IO region (decoded upstream into io_sel).
  localparam logic [3:0] IO_REGION = 4'h8;

  // Register word offsets.
  localparam int OFF_STATUS  = 0;
  localparam int OFF_RXDATA  = 1;
  localparam int OFF_TXDATA  = 2;
  localparam int OFF_CYCLE   = 4;
  localparam int OFF_INSTRET = 5;
  localparam int OFF_CLEAR   = 6;
  localparam int OFF_LEVEL   = 7;

  // Status register, LSB first: tx_not_full is bit0.
  typedef struct packed {
    logic rx_overrun;
    logic tx_overflow;
    logic rx_not_empty;
    logic tx_not_full;
  } status_t;

  // Level register layout: TX level in the upper byte, RX level in the lower byte.
  function automatic logic [15:0] pack_levels(input logic [7:0] tx_lvl, input logic [7:0] rx_lvl);
    return {tx_lvl, rx_lvl};
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// Synchronous FIFO with a combinational head view. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. Full/empty come from
// the level count, so pointer equality is never ambiguous.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state pointers and level; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers; reset discards contents by emptying the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, never reset: stale entries are unreachable once the level is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO UART controller: RX/TX byte FIFOs behind a small register map, plus
// free-running cycle and retired-instruction counters with a shared clear.
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_sel,
  input  logic [ADDR_W-1:0] adr,
  input  logic [3:0]        wea,
  input  logic [XLEN-1:0]   din,
  input  logic              rd_en,
  output logic [XLEN-1:0]   dout,
  input  logic              instr_retire,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_req, rd_req;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic          tx_push, tx_pop, tx_full, tx_empty, tx_push_req;
  logic [7:0]    rx_head, tx_head;
  logic [LW-1:0] rx_level, tx_level;
  logic          clr;
  logic [31:0]   cyc_cnt_q, cyc_cnt_d, ins_cnt_q, ins_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
  logic [XLEN-1:0] rdata, dout_q, dout_d;
  status_t       status;
  logic          unused_din;

  // Only the low byte of a store reaches the TX FIFO.
  assign unused_din = ^din[XLEN-1:8];

  assign wr_req = io_sel && (wea != 4'h0);
  assign rd_req = io_sel && rd_en;
  assign clr    = wr_req && (adr == ADDR_W'(OFF_CLEAR));

  // RX side: accept whenever not full; a read of the data register pops the head.
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd_req && (adr == ADDR_W'(OFF_RXDATA)) && !rx_empty;

  // TX side: a store into a full FIFO survives only if the line drains this cycle.
  assign tx_valid    = !tx_empty;
  assign tx_data     = tx_empty ? 8'h00 : tx_head;
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push_req = wr_req && (adr == ADDR_W'(OFF_TXDATA));
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_data),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(din[7:0]),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  // Counters and sticky flags; a clear write beats that cycle's increment or set.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 32'd1;
    ins_cnt_d = instr_retire ? ins_cnt_q + 32'd1 : ins_cnt_q;
    tx_ovf_d  = tx_ovf_q || (tx_push_req && !tx_push);
    rx_ovr_d  = rx_ovr_q || (rx_valid && rx_full);
    if (clr) begin
      cyc_cnt_d = '0;
      ins_cnt_d = '0;
      tx_ovf_d  = 1'b0;
      rx_ovr_d  = 1'b0;
    end
  end

  // Read mux; unmapped offsets read as zero, and a read of an empty RX FIFO returns zero.
  always_comb begin
    status.tx_not_full  = !tx_full;
    status.rx_not_empty = !rx_empty;
    status.tx_overflow  = tx_ovf_q;
    status.rx_overrun   = rx_ovr_q;
    rdata = '0;
    case (adr)
      ADDR_W'(OFF_STATUS):  rdata = XLEN'(status);
      ADDR_W'(OFF_RXDATA):  rdata = rx_empty ? '0 : XLEN'(rx_head);
      ADDR_W'(OFF_CYCLE):   rdata = XLEN'(cyc_cnt_q);
      ADDR_W'(OFF_INSTRET): rdata = XLEN'(ins_cnt_q);
      ADDR_W'(OFF_LEVEL):   rdata = XLEN'(pack_levels(8'(tx_level), 8'(rx_level)));
      default:              rdata = '0;
    endcase
    dout_d = rd_req ? rdata : dout_q;
  end

  assign dout = dout_q;

  // Register state: counters, sticky flags and the held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      ins_cnt_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ins_cnt_q <= ins_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl with 4-entry FIFOs. Inputs change on the
// falling edge; outputs are checked on the falling edge after the rising edge.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_sel;
  logic [4:0]  adr;
  logic [3:0]  wea;
  logic [31:0] din;
  logic        rd_en;
  logic [31:0] dout;
  logic        instr_retire;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.XLEN(32), .FIFO_DEPTH(4), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .io_sel(io_sel), .adr(adr), .wea(wea), .din(din),
    .rd_en(rd_en), .dout(dout), .instr_retire(instr_retire),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // One-cycle bus read; on return dout holds the result.
  task automatic do_read(input logic [4:0] a);
    io_sel = 1'b1; rd_en = 1'b1; wea = 4'h0; adr = a;
    @(negedge clk);
    io_sel = 1'b0; rd_en = 1'b0;
    $display("rd  adr=0x%0h dout=0x%08h", a, dout);
  endtask

  // One-cycle bus write.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    io_sel = 1'b1; rd_en = 1'b0; wea = 4'hF; adr = a; din = d;
    @(negedge clk);
    io_sel = 1'b0; wea = 4'h0;
    $display("wr  adr=0x%0h din=0x%08h", a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got 0x%08h want 0x00000000", dout); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got 0x%02h want 0x00", tx_data); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    do_read(5'h0);
    n_checks++; if (dout !== 32'h1) begin n_fail++; $display("FAIL reset_status: got 0x%08h want 0x00000001", dout); end
  endtask

  task automatic test_rx_basic();
    rx_valid = 1'b1; rx_data = 8'h41; @(negedge clk);
    rx_data = 8'h42; @(negedge clk);
    rx_valid = 1'b0;
    do_read(5'h7);
    n_checks++; if (dout !== 32'h0000_0002) begin n_fail++; $display("FAIL rx_level: got 0x%08h want 0x00000002", dout); end
    do_read(5'h0);
    n_checks++; if (dout !== 32'h3) begin n_fail++; $display("FAIL rx_status_ne: got 0x%08h want 0x00000003", dout); end
    do_read(5'h1);
    n_checks++; if (dout !== 32'h41) begin n_fail++; $display("FAIL rx_pop0: got 0x%08h want 0x00000041", dout); end
    do_read(5'h1);
    n_checks++; if (dout !== 32'h42) begin n_fail++; $display("FAIL rx_pop1: got 0x%08h want 0x00000042", dout); end
    do_read(5'h1);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rx_pop_empty: got 0x%08h want 0x00000000", dout); end
    do_read(5'h0);
    n_checks++; if (dout !== 32'h1) begin n_fail++; $display("FAIL rx_status_empty: got 0x%08h want 0x00000001", dout); end
    do_read(5'h3);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got 0x%08h want 0x00000000", dout); end
  endtask

  // Push into an empty RX FIFO while reading it in the same cycle.
  task automatic test_rx_same_cycle();
    rx_valid = 1'b1; rx_data = 8'h55;
    do_read(5'h1);
    rx_valid = 1'b0;
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rx_same_cycle_read: got 0x%08h want 0x00000000", dout); end
    do_read(5'h1);
    n_checks++; if (dout !== 32'h55) begin n_fail++; $display("FAIL rx_same_cycle_kept: got 0x%08h want 0x00000055", dout); end
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_write(5'h2, 32'h10 + 32'(i));
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin n_fail++; $display("FAIL tx_head: got valid=%b data=0x%02h want valid=1 data=0x10", tx_valid, tx_data); end
    do_read(5'h7);
    n_checks++; if (dout !== 32'h0000_0400) begin n_fail++; $display("FAIL tx_level_full: got 0x%08h want 0x00000400", dout); end
    do_read(5'h0);
    n_checks++; if (dout !== 32'h4) begin n_fail++; $display("FAIL tx_status_ovf: got 0x%08h want 0x00000004", dout); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL tx_drain%0d: got valid=%b data=0x%02h want valid=1 data=0x%02h", i, tx_valid, tx_data, 8'h10 + 8'(i));
      end
      @(negedge clk);
    end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got valid=%b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  // Full TX FIFO: a store coinciding with a pop is kept and raises no overflow.
  task automatic test_tx_full_push_pop();
    do_write(5'h6, 32'h0);
    for (int i = 0; i < 4; i++) do_write(5'h2, 32'h20 + 32'(i));
    tx_ready = 1'b1;
    do_write(5'h2, 32'h24);
    tx_ready = 1'b0;
    do_read(5'h7);
    n_checks++; if (dout !== 32'h0000_0400) begin n_fail++; $display("FAIL tx_pushpop_level: got 0x%08h want 0x00000400", dout); end
    do_read(5'h0);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL tx_pushpop_status: got 0x%08h want 0x00000000", dout); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h21 + 8'(i)) begin
        n_fail++; $display("FAIL tx_pushpop_drain%0d: got valid=%b data=0x%02h want valid=1 data=0x%02h", i, tx_valid, tx_data, 8'h21 + 8'(i));
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_overrun();
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'h60 + 8'(i);
      n_checks++;
      if (rx_ready !== (i < 4)) begin n_fail++; $display("FAIL rx_ready_%0d: got %b want %b", i, rx_ready, (i < 4)); end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    do_read(5'h0);
    n_checks++; if (dout !== 32'hB) begin n_fail++; $display("FAIL rx_overrun_status: got 0x%08h want 0x0000000b", dout); end
    do_write(5'h6, 32'h0);
    do_read(5'h0);
    n_checks++; if (dout !== 32'h3) begin n_fail++; $display("FAIL rx_overrun_cleared: got 0x%08h want 0x00000003", dout); end
    do_read(5'h7);
    n_checks++; if (dout !== 32'h0000_0004) begin n_fail++; $display("FAIL rx_full_level: got 0x%08h want 0x00000004", dout); end
    do_read(5'h1);
    n_checks++; if (dout !== 32'h60) begin n_fail++; $display("FAIL rx_full_head: got 0x%08h want 0x00000060", dout); end
  endtask

  // Reset with three RX bytes queued and a coincident RX handshake.
  task automatic test_reset_mid_transfer();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_rx_ready: got %b want 1", rx_ready); end
    do_read(5'h7);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL midrst_level: got 0x%08h want 0x00000000", dout); end
    do_read(5'h1);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL midrst_rxdata: got 0x%08h want 0x00000000", dout); end
  endtask

  task automatic test_counters();
    // Clear lands on the first edge; the next 20 edges see retire on every other one.
    do_write(5'h6, 32'h0);
    for (int i = 0; i < 20; i++) begin
      instr_retire = (i % 2 == 0);
      @(negedge clk);
    end
    instr_retire = 1'b0;
    do_read(5'h5);
    n_checks++; if (dout !== 32'd10) begin n_fail++; $display("FAIL instret: got %0d want 10", dout); end
    // Counter was 20 after the loop and 21 once the 0x5 read cycle elapsed.
    do_read(5'h4);
    n_checks++; if (dout !== 32'd21) begin n_fail++; $display("FAIL cycle: got %0d want 21", dout); end
    // Clear with a coincident retire: the clear must win for both counters.
    instr_retire = 1'b1;
    do_write(5'h6, 32'h0);
    instr_retire = 1'b0;
    do_read(5'h4);
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL cycle_after_clear0: got %0d want 0", dout); end
    do_read(5'h4);
    n_checks++; if (dout !== 32'd1) begin n_fail++; $display("FAIL cycle_after_clear1: got %0d want 1", dout); end
    do_read(5'h5);
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL instret_clear_override: got %0d want 0", dout); end
  endtask

  task automatic test_cycle_wrap();
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    do_read(5'h4);
    n_checks++; if (dout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_max: got 0x%08h want 0xffffffff", dout); end
    do_read(5'h4);
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap: got 0x%08h want 0x00000000", dout); end
  endtask

  initial begin
    rst = 1'b1; io_sel = 1'b0; adr = '0; wea = 4'h0; din = '0; rd_en = 1'b0;
    instr_retire = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rx_basic();
    test_rx_same_cycle();
    test_tx_overflow();
    test_tx_full_push_pop();
    test_rx_overrun();
    test_reset_mid_transfer();
    test_counters();
    test_cycle_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
